// File: rtl/video_vga_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : video_vga_capture_if
// Description : Signal bundle between a VGA source and the VGA capture block.
//               master drives the vga_* pins and observes the pix_*/status
//               side; slave (the capture block) samples vga_* and drives the
//               pixel stream, frame/lock/error flags and timing measurements.
//   vga_r/g/b      4b each  colour
//   vga_hsync      1b       horizontal sync, active-high
//   vga_vsync      1b       vertical sync, active-high
//   pix_valid      1b       pix_* carry an active pixel (only while locked)
//   pix_x / pix_y  10b      active column / row
//   pix_rgb        12b      {r,g,b} of that pixel
//   frame_start    1b       pulse at each vsync-anchored hsync edge
//   locked         1b       timing locked
//   err            1b       pulse on any timing violation
//   meas_h_total   11b      last measured line period (clocks)
//   meas_v_total   11b      last measured lines per frame
// Revision    : 1.0 - initial release
// ============================================================================
interface video_vga_capture_if;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [10:0] meas_h_total;
    logic [10:0] meas_v_total;

    modport master (
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err,
               meas_h_total, meas_v_total
    );

    modport slave (
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, err,
               meas_h_total, meas_v_total
    );
endinterface
`default_nettype wire

// File: rtl/video_vga_capture.sv
`default_nettype none
// ============================================================================
// Module      : video_vga_capture
// Description : VGA receiver. Registers the incoming VGA pins, recovers pixel
//               coordinates from the sync edges, measures line and frame
//               timing, and locks after LOCK_FRAMES clean frames following a
//               frame anchor. Pixel outputs appear two clocks after the input.
//   clk  : pixel clock (same clock as the VGA source)
//   rst  : synchronous active-high reset
//   vga  : slave side of video_vga_capture_if (vga_* in, pix_*/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module video_vga_capture #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC       = 96,
    parameter int H_BACK_PORCH = 48,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC       = 2,
    parameter int V_BACK_PORCH = 33,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input wire                 clk,
    input wire                 rst,
    video_vga_capture_if.slave vga
);

    localparam logic [10:0] c_SAT    = 11'h7FF;
    localparam logic [10:0] c_X_LO   = 11'(H_SYNC + H_BACK_PORCH);
    localparam logic [10:0] c_Y_LO   = 11'(V_SYNC + V_BACK_PORCH - 1);
    localparam logic [10:0] c_H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT  = 11'(V_ACTIVE);
    localparam logic [11:0] c_H_TOT  = 12'(H_TOTAL);
    localparam logic [11:0] c_H_SYN  = 12'(H_SYNC);
    localparam logic [11:0] c_V_TOT  = 12'(V_TOTAL);
    localparam logic [7:0]  c_LOCK_N = 8'(LOCK_FRAMES);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    // Stage 1 input registers and edge history
    logic [3:0]  r_s1_r, r_s1_g, r_s1_b;
    logic        r_s1_hs, r_s1_vs, r_hs_prev, r_vs_prev;
    logic        r_s1_vld, r_hist_vld;

    // Timing recovery state
    logic [10:0] r_x_cnt, r_line_cnt;
    logic        r_vs_pend, r_hs_seen, r_anchor_seen;
    logic [1:0]  r_state, w_state_nxt;
    logic [7:0]  r_good, w_good_nxt, w_good_inc;

    // Output registers
    logic        r_pix_valid, r_frame_start, r_locked, r_err;
    logic [9:0]  r_pix_x, r_pix_y;
    logic [11:0] r_pix_rgb;
    logic [10:0] r_meas_h, r_meas_v;

    // Combinational datapath
    logic        w_hs_rise, w_hs_fall, w_vs_rise, w_anchor;
    logic [10:0] w_x_inc, w_x_nxt, w_line_inc, w_line_nxt;
    logic        w_vs_pend_nxt;
    logic [11:0] w_h_period, w_v_lines;
    logic [10:0] w_h_meas, w_v_meas;
    logic [10:0] w_x_off, w_y_off;
    logic        w_viol, w_err;
    logic        w_locked_nxt, w_pix_valid_nxt;
    logic [9:0]  w_pix_x_nxt, w_pix_y_nxt;
    logic [11:0] w_pix_rgb_nxt;

    // ------------------------------------------------------------------
    // Stage 1: register pins. r_hist_vld gates edge detection so the first
    // sample after reset cannot be mistaken for an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_r     <= 4'd0;
            r_s1_g     <= 4'd0;
            r_s1_b     <= 4'd0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_hs_prev  <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_hist_vld <= 1'b0;
        end else begin
            r_s1_r     <= vga.vga_r;
            r_s1_g     <= vga.vga_g;
            r_s1_b     <= vga.vga_b;
            r_s1_hs    <= vga.vga_hsync;
            r_s1_vs    <= vga.vga_vsync;
            r_hs_prev  <= r_s1_hs;
            r_vs_prev  <= r_s1_vs;
            r_s1_vld   <= 1'b1;
            r_hist_vld <= r_s1_vld;
        end
    end

    // ------------------------------------------------------------------
    // Coordinate recovery and violation detection. The *_nxt counter values
    // are the coordinates of the sample currently held in stage 1.
    // ------------------------------------------------------------------
    always_comb begin
        w_hs_rise  = r_hist_vld & r_s1_hs & ~r_hs_prev;
        w_hs_fall  = r_hist_vld & ~r_s1_hs & r_hs_prev;
        w_vs_rise  = r_hist_vld & r_s1_vs & ~r_vs_prev;
        // A vsync rise in the same sample as the hsync rise still anchors.
        w_anchor   = w_hs_rise & (r_vs_pend | w_vs_rise);

        w_x_inc    = (r_x_cnt == c_SAT) ? c_SAT : r_x_cnt + 11'd1;
        w_x_nxt    = w_hs_rise ? 11'd0 : w_x_inc;
        w_line_inc = (r_line_cnt == c_SAT) ? c_SAT : r_line_cnt + 11'd1;
        w_line_nxt = w_anchor ? 11'd0 : (w_hs_rise ? w_line_inc : r_line_cnt);
        w_vs_pend_nxt = w_anchor ? 1'b0 : (r_vs_pend | w_vs_rise);

        // 12-bit so a saturated counter (2047) gives 2048, never wraps to 0.
        w_h_period = {1'b0, r_x_cnt} + 12'd1;
        w_v_lines  = {1'b0, r_line_cnt} + 12'd1;
        w_h_meas   = w_h_period[11] ? c_SAT : w_h_period[10:0];
        w_v_meas   = w_v_lines[11] ? c_SAT : w_v_lines[10:0];

        w_viol = (w_hs_rise & r_hs_seen & (w_h_period != c_H_TOT))
               | (w_hs_fall & r_hs_seen & (w_h_period != c_H_SYN))
               | (w_anchor & r_anchor_seen & (w_v_lines != c_V_TOT))
               | ((w_x_nxt == c_SAT) & (r_x_cnt != c_SAT))
               | ((w_line_nxt == c_SAT) & (r_line_cnt != c_SAT));
        w_err  = w_viol & (r_state != c_ST_SEARCH);

        // Offsets below the window wrap to large values and fail the range test.
        w_x_off = w_x_nxt - c_X_LO;
        w_y_off = w_line_nxt - c_Y_LO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_cnt       <= 11'd0;
            r_line_cnt    <= 11'd0;
            r_vs_pend     <= 1'b0;
            r_hs_seen     <= 1'b0;
            r_anchor_seen <= 1'b0;
            r_meas_h      <= 11'd0;
            r_meas_v      <= 11'd0;
        end else begin
            r_x_cnt    <= w_x_nxt;
            r_line_cnt <= w_line_nxt;
            r_vs_pend  <= w_vs_pend_nxt;
            if (w_hs_rise) begin
                r_hs_seen <= 1'b1;
                if (r_hs_seen) r_meas_h <= w_h_meas;
            end
            if (w_anchor) begin
                r_anchor_seen <= 1'b1;
                if (r_anchor_seen) r_meas_v <= w_v_meas;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_SEARCH;
            r_good  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // Lock FSM: next state. Any violation in CHECK aborts the frame, so an
    // anchor reached in CHECK always closes a clean frame.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_good_inc  = r_good + 8'd1;
        case (r_state)
            c_ST_SEARCH: begin
                if (w_anchor) begin
                    w_state_nxt = c_ST_CHECK;
                    w_good_nxt  = 8'd0;
                end
            end
            c_ST_CHECK: begin
                if (w_err) begin
                    w_state_nxt = c_ST_SEARCH;
                end else if (w_anchor) begin
                    w_good_nxt = w_good_inc;
                    if (w_good_inc == c_LOCK_N) w_state_nxt = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                if (w_err) w_state_nxt = c_ST_SEARCH;
            end
            default: w_state_nxt = c_ST_SEARCH;
        endcase
    end

    // Lock FSM: outputs. pix_valid follows the next lock state so it drops
    // in the same cycle as locked.
    always_comb begin
        w_locked_nxt    = (w_state_nxt == c_ST_LOCKED);
        w_pix_valid_nxt = w_locked_nxt & (w_x_off < c_H_ACT) & (w_y_off < c_V_ACT);
        w_pix_x_nxt     = w_pix_valid_nxt ? w_x_off[9:0] : 10'd0;
        w_pix_y_nxt     = w_pix_valid_nxt ? w_y_off[9:0] : 10'd0;
        w_pix_rgb_nxt   = w_pix_valid_nxt ? {r_s1_r, r_s1_g, r_s1_b} : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_valid   <= 1'b0;
            r_pix_x       <= 10'd0;
            r_pix_y       <= 10'd0;
            r_pix_rgb     <= 12'd0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_pix_valid   <= w_pix_valid_nxt;
            r_pix_x       <= w_pix_x_nxt;
            r_pix_y       <= w_pix_y_nxt;
            r_pix_rgb     <= w_pix_rgb_nxt;
            r_frame_start <= w_anchor;
            r_locked      <= w_locked_nxt;
            r_err         <= w_err;
        end
    end

    assign vga.pix_valid    = r_pix_valid;
    assign vga.pix_x        = r_pix_x;
    assign vga.pix_y        = r_pix_y;
    assign vga.pix_rgb      = r_pix_rgb;
    assign vga.frame_start  = r_frame_start;
    assign vga.locked       = r_locked;
    assign vga.err          = r_err;
    assign vga.meas_h_total = r_meas_h;
    assign vga.meas_v_total = r_meas_v;

endmodule
`default_nettype wire
